// File: rtl/mac_pkg.sv
// Shared descriptor/body layout for the MAC decoder and egress forwarder.
package mac_pkg;

   // Descriptor word: {dst_mask, src_port, len}
   localparam int HDR_W    = 17;
   localparam int MASK_MSB = 16;
   localparam int MASK_LSB = 13;
   localparam int SRC_MSB  = 12;
   localparam int SRC_LSB  = 11;
   localparam int LEN_MSB  = 10;
   localparam int LEN_LSB  = 0;

   // Body word: {eof, byte}
   localparam int BODY_W  = 9;
   localparam int EOF_BIT = 8;

   localparam int N_PORT = 4;

   // Forwarder state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      LOAD   = ST_LOAD,
      STREAM = ST_STREAM,
      DRAIN  = ST_DRAIN
   } fwd_state_t;

   // A frame is never reflected back out of the port it arrived on.
   function automatic logic [N_PORT-1:0] eff_mask(input logic [N_PORT-1:0] dst,
                                                  input logic [1:0]        src);
      return dst & ~(N_PORT'(1) << src);
   endfunction

endpackage

// File: rtl/mac_sat_cnt.sv
// Saturating statistics counter with synchronous clear.
module mac_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/mac_fwd.sv
// Egress forwarder: pops one descriptor per frame, then copies the frame body
// into every selected outbound PHY FIFO in lock-step, or drains it when no
// port is selected. Keeps forwarded/dropped/length-error statistics.
module mac_fwd
   import mac_pkg::*;
#(
   parameter int LEN_W = 11,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HDR_W-1:0]  h_fifo_dout,
   input  logic              h_fifo_empty,
   output logic              h_fifo_rden,
   input  logic [BODY_W-1:0] b_fifo_dout,
   input  logic              b_fifo_empty,
   output logic              b_fifo_rden,
   output logic [BODY_W-1:0] o0_fifo_din,
   output logic              o0_fifo_wren,
   input  logic              o0_fifo_afull,
   output logic [BODY_W-1:0] o1_fifo_din,
   output logic              o1_fifo_wren,
   input  logic              o1_fifo_afull,
   output logic [BODY_W-1:0] o2_fifo_din,
   output logic              o2_fifo_wren,
   input  logic              o2_fifo_afull,
   output logic [BODY_W-1:0] o3_fifo_din,
   output logic              o3_fifo_wren,
   input  logic              o3_fifo_afull,
   output logic              busy,
   output logic [CNT_W-1:0]  frm_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   fwd_state_t state_q, state_d;

   logic [N_PORT-1:0] mask_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  cnt_inc;
   logic              len_err;
   logic              go;
   logic              body_eof;
   logic              frm_inc;
   logic              drop_inc;
   logic              err_inc;
   logic [N_PORT-1:0] afull_vec;
   logic [N_PORT-1:0] wren_q;
   logic [BODY_W-1:0] din_q [N_PORT];

   assign afull_vec = {o3_fifo_afull, o2_fifo_afull, o1_fifo_afull, o0_fifo_afull};
   assign body_eof  = b_fifo_dout[EOF_BIT];
   assign cnt_inc   = cnt_q + LEN_W'(1);
   assign len_err   = (cnt_inc != len_q);
   assign busy      = (state_q != IDLE);

   // Next-state and FIFO pop strobes; reset suppresses every pop so a reset
   // mid-frame leaves the input FIFOs untouched.
   always_comb begin
      state_d     = state_q;
      h_fifo_rden = 1'b0;
      b_fifo_rden = 1'b0;
      go          = 1'b0;
      frm_inc     = 1'b0;
      drop_inc    = 1'b0;
      err_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!h_fifo_empty) begin
               h_fifo_rden = 1'b1;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            state_d = (mask_q != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            go          = !b_fifo_empty && !(|(mask_q & afull_vec));
            b_fifo_rden = go;
            if (go && body_eof) begin
               state_d = IDLE;
               frm_inc = 1'b1;
               err_inc = len_err;
            end
         end
         DRAIN: begin
            b_fifo_rden = !b_fifo_empty;
            if (!b_fifo_empty && body_eof) begin
               state_d  = IDLE;
               drop_inc = 1'b1;
               err_inc  = len_err;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         h_fifo_rden = 1'b0;
         b_fifo_rden = 1'b0;
         go          = 1'b0;
         frm_inc     = 1'b0;
         drop_inc    = 1'b0;
         err_inc     = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Latch the descriptor on pop and count body bytes; the count saturates so
   // oversized frames still stream to their eof without wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         if (h_fifo_rden) begin
            mask_q <= eff_mask(h_fifo_dout[MASK_MSB:MASK_LSB], h_fifo_dout[SRC_MSB:SRC_LSB]);
            len_q  <= LEN_W'(h_fifo_dout[LEN_MSB:LEN_LSB]);
         end
         if (state_q == LOAD)
            cnt_q <= '0;
         else if (b_fifo_rden && (cnt_q != '1))
            cnt_q <= cnt_inc;
      end
   end

   // Outbound write stage, one cycle behind the pop; ports outside the mask
   // keep their last data so idle buses do not toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wren_q <= '0;
         for (int n = 0; n < N_PORT; n++)
            din_q[n] <= '0;
      end else begin
         for (int n = 0; n < N_PORT; n++) begin
            wren_q[n] <= go && mask_q[n];
            if (go && mask_q[n])
               din_q[n] <= b_fifo_dout;
         end
      end
   end

   assign o0_fifo_wren = wren_q[0];
   assign o1_fifo_wren = wren_q[1];
   assign o2_fifo_wren = wren_q[2];
   assign o3_fifo_wren = wren_q[3];
   assign o0_fifo_din  = din_q[0];
   assign o1_fifo_din  = din_q[1];
   assign o2_fifo_din  = din_q[2];
   assign o3_fifo_din  = din_q[3];

   mac_sat_cnt #(.W(CNT_W)) u_frm_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (frm_inc),
      .count (frm_cnt)
   );

   mac_sat_cnt #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (drop_inc),
      .count (drop_cnt)
   );

   mac_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (err_inc),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_mac_fwd.sv
// Directed bench for mac_fwd with behavioural header/body FIFOs and
// capture of every outbound write.
module tb_mac_fwd;

   logic        clk;
   logic        rst;
   logic [16:0] h_fifo_dout;
   logic        h_fifo_empty;
   logic        h_fifo_rden;
   logic [8:0]  b_fifo_dout;
   logic        b_fifo_empty;
   logic        b_fifo_rden;
   logic [8:0]  o0_fifo_din, o1_fifo_din, o2_fifo_din, o3_fifo_din;
   logic        o0_fifo_wren, o1_fifo_wren, o2_fifo_wren, o3_fifo_wren;
   logic        o0_fifo_afull, o1_fifo_afull, o2_fifo_afull, o3_fifo_afull;
   logic        busy;
   logic [15:0] frm_cnt, drop_cnt, err_cnt;

   int total = 0;
   int bad   = 0;

   // FIFO models
   logic [16:0] hmem [0:63];
   logic [8:0]  bmem [0:63];
   int hwr = 0, hrd = 0, bwr = 0, brd = 0;
   int cyc = 0;

   // Capture of outbound writes and header pops
   logic [8:0] omem   [4][0:63];
   int         ostamp [4][0:63];
   int         ocnt   [4];
   int         hstamp [0:63];
   int         hn = 0;
   logic [3:0] owren;
   logic [8:0] odin [4];

   assign h_fifo_dout  = hmem[hrd];
   assign h_fifo_empty = (hrd == hwr);
   assign b_fifo_dout  = bmem[brd];
   assign b_fifo_empty = (brd == bwr);
   assign owren   = {o3_fifo_wren, o2_fifo_wren, o1_fifo_wren, o0_fifo_wren};
   assign odin[0] = o0_fifo_din;
   assign odin[1] = o1_fifo_din;
   assign odin[2] = o2_fifo_din;
   assign odin[3] = o3_fifo_din;

   mac_fwd #(.LEN_W(11), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .h_fifo_dout   (h_fifo_dout),
      .h_fifo_empty  (h_fifo_empty),
      .h_fifo_rden   (h_fifo_rden),
      .b_fifo_dout   (b_fifo_dout),
      .b_fifo_empty  (b_fifo_empty),
      .b_fifo_rden   (b_fifo_rden),
      .o0_fifo_din   (o0_fifo_din),
      .o0_fifo_wren  (o0_fifo_wren),
      .o0_fifo_afull (o0_fifo_afull),
      .o1_fifo_din   (o1_fifo_din),
      .o1_fifo_wren  (o1_fifo_wren),
      .o1_fifo_afull (o1_fifo_afull),
      .o2_fifo_din   (o2_fifo_din),
      .o2_fifo_wren  (o2_fifo_wren),
      .o2_fifo_afull (o2_fifo_afull),
      .o3_fifo_din   (o3_fifo_din),
      .o3_fifo_wren  (o3_fifo_wren),
      .o3_fifo_afull (o3_fifo_afull),
      .busy          (busy),
      .frm_cnt       (frm_cnt),
      .drop_cnt      (drop_cnt),
      .err_cnt       (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO pop side and outbound capture; the FIFOs are flushed alongside the DUT reset.
   initial for (int n = 0; n < 4; n++) ocnt[n] = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         hrd <= hwr;
         brd <= bwr;
      end else begin
         if (h_fifo_rden) begin
            hrd        <= hrd + 1;
            hstamp[hn] <= cyc;
            hn         <= hn + 1;
         end
         if (b_fifo_rden)
            brd <= brd + 1;
      end
      for (int n = 0; n < 4; n++) begin
         if (owren[n]) begin
            omem[n][ocnt[n]]   <= odin[n];
            ostamp[n][ocnt[n]] <= cyc;
            ocnt[n]            <= ocnt[n] + 1;
         end
      end
   end

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input logic [1:0] src, input logic [10:0] len);
      hmem[hwr] = {mask, src, len};
      hwr       = hwr + 1;
   endtask

   task automatic pushByte(input logic eof, input logic [7:0] b);
      bmem[bwr] = {eof, b};
      bwr       = bwr + 1;
   endtask

   task automatic waitDone(input string tag);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (!busy && (hrd == hwr) && (brd == bwr))
            done = 1'b1;
      end
      checkOutput(tag, 32'(done), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic waitWrites(input string tag, input int port, input int target);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (ocnt[port] >= target)
            done = 1'b1;
      end
      checkOutput(tag, 32'(done), 32'd1);
   endtask

   // Directed sequence
   initial begin
      int base [4];
      int hb;
      int s_brd;
      int viol;

      rst           = 1'b1;
      o0_fifo_afull = 1'b0;
      o1_fifo_afull = 1'b0;
      o2_fifo_afull = 1'b0;
      o3_fifo_afull = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_wren", 32'(owren), 0);
      checkOutput("rst_frm", 32'(frm_cnt), 0);
      checkOutput("rst_drop", 32'(drop_cnt), 0);
      checkOutput("rst_err", 32'(err_cnt), 0);
      checkOutput("rst_rden", 32'({h_fifo_rden, b_fifo_rden}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Frame to ports 1 and 2
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      pushByte(1'b0, 8'h11);
      pushByte(1'b0, 8'h22);
      pushByte(1'b0, 8'h33);
      pushByte(1'b1, 8'h44);
      applyStimulus(4'b0110, 2'd0, 11'd4);
      waitDone("t1_done");
      checkOutput("t1_o1_cnt", 32'(ocnt[1] - base[1]), 4);
      checkOutput("t1_o2_cnt", 32'(ocnt[2] - base[2]), 4);
      checkOutput("t1_o0_cnt", 32'(ocnt[0] - base[0]), 0);
      checkOutput("t1_o3_cnt", 32'(ocnt[3] - base[3]), 0);
      checkOutput("t1_o1_b0", 32'(omem[1][base[1]]),     32'h011);
      checkOutput("t1_o1_b1", 32'(omem[1][base[1] + 1]), 32'h022);
      checkOutput("t1_o1_b2", 32'(omem[1][base[1] + 2]), 32'h033);
      checkOutput("t1_o1_b3", 32'(omem[1][base[1] + 3]), 32'h144);
      checkOutput("t1_o2_b0", 32'(omem[2][base[2]]),     32'h011);
      checkOutput("t1_o2_b3", 32'(omem[2][base[2] + 3]), 32'h144);
      checkOutput("t1_span", 32'(ostamp[1][base[1] + 3] - ostamp[1][base[1]]), 3);
      checkOutput("t1_lockstep", 32'(ostamp[2][base[2] + 3] - ostamp[1][base[1] + 3]), 0);
      checkOutput("t1_frm", 32'(frm_cnt), 1);
      checkOutput("t1_err", 32'(err_cnt), 0);

      // Mask reduces to nothing once the source port is removed: drained, dropped
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      for (int i = 0; i < 4; i++) pushByte(i == 3, 8'h70 + 8'(i));
      applyStimulus(4'b0001, 2'd0, 11'd4);
      waitDone("t2_done");
      checkOutput("t2_wr", 32'((ocnt[0] - base[0]) + (ocnt[1] - base[1]) + (ocnt[2] - base[2]) + (ocnt[3] - base[3])), 0);
      checkOutput("t2_drop", 32'(drop_cnt), 1);
      checkOutput("t2_frm", 32'(frm_cnt), 1);
      checkOutput("t2_err", 32'(err_cnt), 0);

      // Broadcast excluding source port 2, with a 10-cycle stall on port 3
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      for (int i = 0; i < 6; i++) pushByte(i == 5, 8'hA1 + 8'(i));
      applyStimulus(4'b1111, 2'd2, 11'd6);
      waitWrites("t3_start", 0, base[0] + 2);
      o3_fifo_afull = 1'b1;
      s_brd = brd;
      viol  = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (b_fifo_rden) viol++;
         if (k > 0 && owren != 4'b0000) viol++;
         @(negedge clk);
      end
      checkOutput("t3_stall_viol", 32'(viol), 0);
      checkOutput("t3_stall_pops", 32'(brd - s_brd), 0);
      o3_fifo_afull = 1'b0;
      waitDone("t3_done");
      checkOutput("t3_o2_cnt", 32'(ocnt[2] - base[2]), 0);
      checkOutput("t3_o0_cnt", 32'(ocnt[0] - base[0]), 6);
      checkOutput("t3_o1_cnt", 32'(ocnt[1] - base[1]), 6);
      checkOutput("t3_o3_cnt", 32'(ocnt[3] - base[3]), 6);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("t3_o3_b%0d", i), 32'(omem[3][base[3] + i]), 32'({i == 5, 8'hA1 + 8'(i)}));
         checkOutput($sformatf("t3_o0_b%0d", i), 32'(omem[0][base[0] + i]), 32'({i == 5, 8'hA1 + 8'(i)}));
      end
      checkOutput("t3_frm", 32'(frm_cnt), 2);

      // Two queued descriptors whose eof disagrees with len (short, then long)
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      hb = hn;
      pushByte(1'b0, 8'h31);
      pushByte(1'b0, 8'h32);
      pushByte(1'b1, 8'h33);
      pushByte(1'b0, 8'h41);
      pushByte(1'b0, 8'h42);
      pushByte(1'b0, 8'h43);
      pushByte(1'b1, 8'h44);
      applyStimulus(4'b0010, 2'd0, 11'd5);
      applyStimulus(4'b0100, 2'd0, 11'd2);
      waitDone("t4_done");
      checkOutput("t4_hpops", 32'(hn - hb), 2);
      checkOutput("t4_hgap", 32'(hstamp[hb + 1] - hstamp[hb]), 5);
      checkOutput("t4_o1_cnt", 32'(ocnt[1] - base[1]), 3);
      checkOutput("t4_o2_cnt", 32'(ocnt[2] - base[2]), 4);
      checkOutput("t4_o1_last", 32'(omem[1][base[1] + 2]), 32'h133);
      checkOutput("t4_o2_first", 32'(omem[2][base[2]]), 32'h041);
      checkOutput("t4_o2_last", 32'(omem[2][base[2] + 3]), 32'h144);
      checkOutput("t4_frm", 32'(frm_cnt), 4);
      checkOutput("t4_err", 32'(err_cnt), 2);
      checkOutput("t4_drop", 32'(drop_cnt), 1);

      // Reset in the middle of a frame, then a fresh frame
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      for (int i = 0; i < 6; i++) pushByte(i == 5, 8'h51 + 8'(i));
      applyStimulus(4'b0001, 2'd1, 11'd6);
      waitWrites("t6_start", 0, base[0] + 1);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_rden", 32'({h_fifo_rden, b_fifo_rden}), 0);
      @(negedge clk);
      checkOutput("t6_rst_wren", 32'(owren), 0);
      checkOutput("t6_rst_busy", 32'(busy), 0);
      checkOutput("t6_rst_cnts", 32'({frm_cnt, err_cnt}) | 32'(drop_cnt), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 4; n++) base[n] = ocnt[n];
      pushByte(1'b0, 8'h61);
      pushByte(1'b1, 8'h62);
      applyStimulus(4'b1000, 2'd0, 11'd2);
      waitDone("t7_done");
      checkOutput("t7_o3_cnt", 32'(ocnt[3] - base[3]), 2);
      checkOutput("t7_o0_cnt", 32'(ocnt[0] - base[0]), 0);
      checkOutput("t7_o3_b0", 32'(omem[3][base[3]]), 32'h061);
      checkOutput("t7_o3_b1", 32'(omem[3][base[3] + 1]), 32'h162);
      checkOutput("t7_frm", 32'(frm_cnt), 1);
      checkOutput("t7_err", 32'(err_cnt), 0);
      checkOutput("t7_drop", 32'(drop_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
